// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: state encoding, pipeline tag, index sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Number of bits needed to index n items (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Tag index is sized for the largest supported core count (64).
  localparam int TAG_IDX_WID = 6;

  // Command-stage tag travelling alongside the RAM access.
  typedef struct packed {
    logic                   vld;
    logic [TAG_IDX_WID-1:0] idx;
    logic                   rd;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/grant bus plus the single-port RAM port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held by a core until its gnt; RAM side never stalls.
interface mem_arbiter_if #(
  parameter int CORE_CNT = 16,
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32
);
  logic [CORE_CNT-1:0]          req;
  logic [CORE_CNT-1:0]          we;
  logic [CORE_CNT-1:0]          lock;
  logic [CORE_CNT*ADDR_WID-1:0] addr;
  logic [CORE_CNT*DATA_WID-1:0] wdata;
  logic [CORE_CNT-1:0]          gnt;
  logic [CORE_CNT-1:0]          rvalid;
  logic [DATA_WID-1:0]          rdata;
  logic                         mem_en;
  logic                         mem_we;
  logic [ADDR_WID-1:0]          mem_addr;
  logic [DATA_WID-1:0]          mem_wdata;
  logic [DATA_WID-1:0]          mem_rdata;

  // Arbiter side.
  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Cores plus RAM side.
  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit searching from ptr+1, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is set.
module rr_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W:0] pos;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = N; i >= 1; i--) begin
      pos = {1'b0, ptr} + (W+1)'(i);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      if (req[pos[W-1:0]]) begin
        idx = pos[W-1:0];
        any = 1'b1;
      end
    end
    if (any) begin
      gnt = N'(1) << idx;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Work-conserving round-robin arbiter sharing one single-port RAM, with bounded lock bursts.
// Latency: gnt same cycle as req, RAM command next cycle, rvalid/rdata two cycles after gnt.
// Backpressure: ungranted cores hold req; one grant per cycle, no bubbles, RAM never stalls.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CORE_CNT  = 16,
  parameter int IDX_WID   = clog2(CORE_CNT),
  parameter int ADDR_WID  = 32,
  parameter int DATA_WID  = 32,
  parameter int MAX_BURST = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  arb_state_t          state, state_nxt;
  logic [IDX_WID-1:0]  ptr;
  logic [7:0]          burst_cnt, burst_nxt;
  logic [CORE_CNT-1:0] pick_gnt, gnt;
  logic [IDX_WID-1:0]  pick_idx, idx;
  logic                pick_any, any;
  logic                owner_hold, others_req;
  tag_t                p1;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_WID-1:0] mem_addr_q;
  logic [DATA_WID-1:0] mem_wdata_q;
  logic [CORE_CNT-1:0] rvalid_q;
  logic [ADDR_WID-1:0] addr_arr  [CORE_CNT];
  logic [DATA_WID-1:0] wdata_arr [CORE_CNT];

  for (genvar g = 0; g < CORE_CNT; g++) begin : g_unpack
    assign addr_arr[g]  = bus.addr[g*ADDR_WID +: ADDR_WID];
    assign wdata_arr[g] = bus.wdata[g*DATA_WID +: DATA_WID];
  end

  // Normal search and burst-exit search share this picker: ptr holds the burst owner.
  rr_pick #(.N(CORE_CNT), .W(IDX_WID)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Burst owner keeps the grant unless it drops lock/req or has used its budget while others wait.
  always_comb begin
    others_req = |(bus.req & ~(CORE_CNT'(1) << ptr));
    owner_hold = (state == BURST) && bus.req[ptr] && bus.lock[ptr] &&
                 !((burst_cnt == 8'(MAX_BURST)) && others_req);
  end

  // Grant selection and burst FSM next state.
  always_comb begin
    gnt       = pick_gnt;
    idx       = pick_idx;
    any       = pick_any;
    state_nxt = ARB;
    burst_nxt = '0;
    if (owner_hold) begin
      gnt       = CORE_CNT'(1) << ptr;
      idx       = ptr;
      any       = 1'b1;
      state_nxt = BURST;
      burst_nxt = (burst_cnt == 8'(MAX_BURST)) ? 8'(MAX_BURST) : burst_cnt + 8'd1;
    end else if (pick_any && bus.lock[pick_idx]) begin
      state_nxt = BURST;
      burst_nxt = 8'd1;
    end
    // A grant during reset would be silently dropped, so never show one.
    if (!rst) begin
      gnt = '0;
      any = 1'b0;
    end
  end

  // Arbitration state: FSM, round-robin pointer, burst length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARB;
      ptr       <= IDX_WID'(CORE_CNT - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (any) begin
        ptr <= idx;
      end
    end
  end

  // Command stage: register the winner's access; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p1          <= '0;
    end else begin
      mem_en_q <= any;
      mem_we_q <= any && bus.we[idx];
      p1.vld   <= any;
      p1.idx   <= TAG_IDX_WID'(idx);
      p1.rd    <= !bus.we[idx];
      if (any) begin
        mem_addr_q  <= addr_arr[idx];
        mem_wdata_q <= wdata_arr[idx];
      end
    end
  end

  // Return stage: pulse rvalid for the read whose RAM data appears this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= (p1.vld && p1.rd) ? (CORE_CNT'(1) << p1.idx) : '0;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Request/grant arbiter that shares one single-port block RAM among CORE_CNT cores in the many-core SoC. It replaces fixed time-slot token passing with work-conserving round-robin: idle cores are skipped. An optional per-core lock supports bounded bursts. It registers the memory command and returns read data with a per-core valid pulse, matched to the RAM's 1-cycle read latency.

Parameters:
CORE_CNT, 16, number of requesting cores (2..64)
IDX_WID, 4, width of core index, = clog2(CORE_CNT)
ADDR_WID, 32, memory address width
DATA_WID, 32, memory data width
MAX_BURST, 8, max consecutive grants to one locked core while others wait (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
req  input  CORE_CNT  per-core request, held until granted
we  input  CORE_CNT  per-core write flag, valid with req
lock  input  CORE_CNT  per-core burst hold request
addr  input  CORE_CNT*ADDR_WID  per-core address, flattened, core i at [i*ADDR_WID +: ADDR_WID]
wdata  input  CORE_CNT*DATA_WID  per-core write data, flattened
gnt  output  CORE_CNT  one-hot grant; request accepted this cycle
rvalid  output  CORE_CNT  one-hot read-return pulse
rdata  output  DATA_WID  read data, broadcast, qualified by rvalid
mem_en  output  1  RAM enable
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WID  RAM address
mem_wdata  output  DATA_WID  RAM write data
mem_rdata  input  DATA_WID  RAM read data, valid 1 cycle after a read command

Behaviour:
- Reset (rst=0 at posedge): ptr=CORE_CNT-1, burst_cnt=0, state=ARB.
  - All outputs are 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata.
  - In-flight pipeline entries are discarded; no rvalid is produced for them.
- Arbitration (combinational, cycle N): search req starting at (ptr+1) mod CORE_CNT, wrapping; the first set bit wins (idx).
  - gnt[idx]=1 in cycle N. No req -> gnt=0.
  - gnt is combinational from req, ptr, state and burst_cnt.
- Handshake: req[i]&gnt[i] = transfer accepted. The core may change addr/we/wdata/req in N+1. An ungranted req must stay stable.
- Command stage (registered, N+1):
  - mem_en=1, mem_we=we[idx], mem_addr/mem_wdata=selected core's fields.
  - Pipeline tag p1={vld, idx, rd}.
  - mem_en=0 when no grant; mem_addr/mem_wdata then hold their previous values.
- Return stage (N+2): for a read, rvalid[idx]=1 for one cycle and rdata=mem_rdata. Writes produce no rvalid. Read latency req->rvalid is 2 cycles.
- Throughput: one grant per cycle, no bubbles; back-to-back grants to the same or different cores are allowed.
- ptr update: on every grant, ptr<=idx.
- FSM states ARB and BURST:
  - ARB -> BURST: granted core has lock[idx]=1; burst_cnt<=1.
  - In BURST, the owner keeps priority: if req[owner], gnt owner and increment burst_cnt.
  - BURST -> ARB: lock[owner] drops, or owner has no req, or burst_cnt==MAX_BURST while any other req is set. That cycle arbitrates normally from ptr=owner, so another core wins.
  - At burst_cnt==MAX_BURST with no other requester, the owner continues; burst_cnt saturates at MAX_BURST.
- Wrap: ptr=CORE_CNT-1 searches from 0. Index arithmetic is mod CORE_CNT; non-power-of-2 CORE_CNT is supported.
- Simultaneous events: a new grant in cycle N and an rvalid for an earlier grant in the same cycle are independent. A core may be granted in the same cycle it receives rvalid.

Decomposition:
- Package mem_arb_pkg: IDX_WID computation (clog2 function), state encoding (ARB=0, BURST=1), pipeline tag field layout.
- One sub-module, rr_pick: combinational rotating priority picker. Inputs are req vector and ptr; outputs are one-hot gnt, idx and any. It is reused by the burst-exit path.

Test Plan:
1. Reset, then req=16'h0001, we=0, addr0=0x10 -> gnt[0] in cycle 1, mem_en=1 and mem_addr=0x10 in cycle 2, rvalid[0] with rdata=RAM[0x10] in cycle 3.
2. All 16 req held continuously, no lock -> grant order 0,1,...,15,0, one per cycle, no gaps.
3. req={3,7,12} only -> order 3,7,12,3; cores 4-6 are never granted; mem_en is high every cycle.
4. Core 2 lock=1 with req held, core 5 req held, MAX_BURST=8 -> gnt[2] 8 consecutive cycles, then gnt[5], then gnt[2] again.
5. Core 9 lock and req held, no other req -> gnt[9] continuous beyond 8 cycles; burst_cnt stays 8.
6. Write 0xDEADBEEF to 0x40 by core 1, then read 0x40 by core 4 one cycle later -> rvalid[4] with rdata=0xDEADBEEF. Reset asserted while read in flight -> no rvalid.
